// File: rtl/bit_stuffer_hs.sv
// bit_stuffer_hs: flow-controlled USB TX bit stuffer with a saturating count of stuffed bits
module bit_stuffer_hs #(
  parameter int RUN_LEN = 6,
  parameter bit RUN_BIT = 1'b1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             stuff_en,
  input  logic             clr,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_stuff,
  output logic [CNT_W-1:0] stuff_cnt
);
  localparam int RW = $clog2(RUN_LEN + 1);
  typedef enum logic [1:0] {INIT, PASS, STUFF} state_t;
  state_t state, state_nx;
  logic [RW-1:0] run, run_inc;
  logic load, acc, is_run, hit;
  // handshake and run-length detection; hit marks the bit that completes a run
  always_comb begin
    load     = !out_valid | out_ready;
    in_ready = !RST & !clr & (state == PASS) & load;
    acc      = in_valid & in_ready;
    is_run   = stuff_en & (in_bit == RUN_BIT);
    run_inc  = run + 1'b1;
    hit      = acc & is_run & (run_inc == RW'(RUN_LEN));
  end
  // next state: a completed run goes to STUFF, which holds until the output register frees up
  always_comb begin
    state_nx = clr ? PASS :
               state == INIT ? PASS :
               state == PASS ? (hit ? STUFF : PASS) :
               (load ? PASS : STUFF);
  end
  // state register
  always_ff @(posedge clk) begin
    if (RST) state <= INIT;
    else state <= state_nx;
  end
  // output register, run counter and stuff counter
  always_ff @(posedge clk) begin
    if (RST) begin
      run          <= '0;
      out_bit      <= 1'b0;
      out_valid    <= 1'b0;
      out_is_stuff <= 1'b0;
      stuff_cnt    <= '0;
    end else if (clr) begin
      run          <= '0;
      out_valid    <= 1'b0;
      out_is_stuff <= 1'b0;
      stuff_cnt    <= '0;
    end else if (state == STUFF) begin
      if (load) begin
        out_bit      <= ~RUN_BIT;
        out_valid    <= 1'b1;
        out_is_stuff <= 1'b1;
        stuff_cnt    <= stuff_cnt + CNT_W'(~&stuff_cnt);
      end
    end else if (acc) begin
      out_bit      <= in_bit;
      out_valid    <= 1'b1;
      out_is_stuff <= 1'b0;
      run          <= (hit | !is_run) ? '0 : run_inc;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bit_stuffer_hs.sv
// tb_bit_stuffer_hs: randomized and directed check of bit_stuffer_hs against a queue-based stream model
module tb_bit_stuffer_hs;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, stuff_en = 1'b1, clr = 1'b0, in_bit = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic a_ir, a_ob, a_ov, a_is, b_ir, b_ob, b_ov, b_is;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;
  bit sel;
  logic ir, ob, ov, os;
  int cnt;
  assign ir  = sel ? b_ir : a_ir;
  assign ob  = sel ? b_ob : a_ob;
  assign ov  = sel ? b_ov : a_ov;
  assign os  = sel ? b_is : a_is;
  assign cnt = sel ? int'(b_cnt) : int'(a_cnt);

  bit_stuffer_hs dut_a (.clk(clk), .RST(rst), .stuff_en(stuff_en), .clr(clr), .in_bit(in_bit),
    .in_valid(in_valid), .in_ready(a_ir), .out_bit(a_ob), .out_valid(a_ov), .out_ready(out_ready),
    .out_is_stuff(a_is), .stuff_cnt(a_cnt));
  bit_stuffer_hs #(.RUN_LEN(3), .RUN_BIT(1'b0), .CNT_W(2)) dut_b (.clk(clk), .RST(rst),
    .stuff_en(stuff_en), .clr(clr), .in_bit(in_bit), .in_valid(in_valid), .in_ready(b_ir),
    .out_bit(b_ob), .out_valid(b_ov), .out_ready(out_ready), .out_is_stuff(b_is), .stuff_cnt(b_cnt));

  typedef struct { bit b; bit s; } item_t;
  item_t q[$];
  int rl = 6, cmax = 255, run = 0, nstuff = 0;
  bit rb = 1'b1, init = 1'b1;
  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input bit r, input bit c, input bit v, input bit b, input bit o, input bit en,
                     output bit acc);
    int pend, loaded;
    bit eir;
    @(negedge clk);
    rst = r; clr = c; in_valid = v; in_bit = b; out_ready = o; stuff_en = en;
    #1;
    pend = 0;
    for (int i = 1; i < q.size(); i++) if (q[i].s) pend++;
    loaded = nstuff - pend;
    check("out_valid", ov, q.size() > 0);
    if (q.size() > 0) begin
      check("out_bit", ob, q[0].b);
      check("out_is_stuff", os, q[0].s);
    end
    check("stuff_cnt", cnt, loaded > cmax ? cmax : loaded);
    eir = !r && !c && !init && pend == 0 && (q.size() == 0 || o);
    check("in_ready", ir, eir);
    acc = v && eir;
    if (r) begin
      q.delete(); run = 0; nstuff = 0; init = 1'b1;
    end else if (c) begin
      q.delete(); run = 0; nstuff = 0; init = 1'b0;
    end else begin
      init = 1'b0;
      if (q.size() > 0 && o) void'(q.pop_front());
      if (acc) begin
        q.push_back('{b, 1'b0});
        if (en && b == rb) begin
          run++;
          if (run == rl) begin
            run = 0;
            nstuff++;
            q.push_back('{!rb, 1'b1});
          end
        end else run = 0;
      end
    end
  endtask

  task automatic send(input bit en, input bit b);
    bit acc;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b1, b, 1'b1, en, acc);
      if (acc) return;
    end
    check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
  endtask

  task automatic rand_run(input int n);
    bit acc;
    for (int i = 0; i < n; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
          ($urandom_range(0, 9) < 8) ? rb : !rb, $urandom_range(0, 3) != 0,
          $urandom_range(0, 19) != 0, acc);
  endtask

  initial begin
    bit acc;
    int pat[12] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
    repeat (2) @(posedge clk);
    for (int i = 0; i < 8; i++) send(1'b1, 1'b1);
    idle(3);
    foreach (pat[i]) send(1'b1, pat[i][0]);
    idle(3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 6; i++) send(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    for (int i = 0; i < 2; i++) send(1'b1, 1'b1);
    idle(3);
    for (int i = 0; i < 20; i++) send(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send(1'b1, 1'b1);
    idle(3);
    for (int i = 0; i < 6; i++) send(1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, acc);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b1);
    idle(3);
    rand_run(3000);
    idle(3);
    sel = 1'b1; rl = 3; rb = 1'b0; cmax = 3;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 15; i++) send(1'b1, 1'b0);
    idle(2);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
    idle(3);
    rand_run(3000);
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
